// File: rtl/reset_sequencer_if.sv
// Reset sequencer control bundle: PLL lock / software request in, staged resets and status out.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  PLL_LOCK;
  logic                  SW_RST;
  logic [NUM_STAGES-1:0] RST_OUT_N;
  logic                  READY;
  logic [2:0]            STATE;

  modport master (output PLL_LOCK, SW_RST, input RST_OUT_N, READY, STATE);
  modport slave  (input PLL_LOCK, SW_RST, output RST_OUT_N, READY, STATE);
endinterface

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: qualifies PLL lock, stretches reset, releases domain resets
// one stage at a time, then raises READY. Lock loss or SW_RST restarts from WAIT_LOCK.
module reset_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int LOCK_FILTER    = 8,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4
) (
  input  logic              CK,
  input  logic              RSTN,
  reset_sequencer_if.slave  bus
);

  localparam int MAXC0 = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
  localparam int MAXC  = (MAXC0 > STAGE_GAP) ? MAXC0 : STAGE_GAP;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int IW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] LF_END  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] SC_END  = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  rdy_q, rdy_d;
  logic                  abort;

  // Lock loss outranks SW_RST, but both land in the same cleared state.
  assign abort = ((state_q == STRETCH) || (state_q == RELEASE) || (state_q == RUN)) &&
                 (!bus.PLL_LOCK || bus.SW_RST);

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:      state_d = WAIT_LOCK;
      WAIT_LOCK: if (bus.PLL_LOCK && cnt_q == LF_END) state_d = STRETCH;
      STRETCH:   if (abort) state_d = WAIT_LOCK;
                 else if (cnt_q == SC_END) state_d = RELEASE;
      RELEASE:   if (abort) state_d = WAIT_LOCK;
                 else if (cnt_q == GAP_END && idx_q == LAST) state_d = RUN;
      RUN:       if (abort) state_d = WAIT_LOCK;
      default:   state_d = HOLD;
    endcase
  end

  // Next values of the registered outputs and shared counter / stage index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    rst_d = rst_q;
    rdy_d = rdy_q;
    if (abort) begin
      cnt_d = '0;
      idx_d = '0;
      rst_d = '0;
      rdy_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!bus.PLL_LOCK || cnt_q == LF_END) cnt_d = '0;
          else                                  cnt_d = cnt_q + CW'(1);
        end
        STRETCH: begin
          if (cnt_q == SC_END) begin
            cnt_d = '0;
            rst_d = NUM_STAGES'({rst_q, 1'b1});
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_END) begin
            cnt_d = '0;
            if (idx_q != LAST) begin
              idx_d = idx_q + IW'(1);
              // Stages release in order, so shifting in a 1 frees exactly the next one.
              rst_d = NUM_STAGES'({rst_q, 1'b1});
            end else begin
              rdy_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.RST_OUT_N = rst_q;
  assign bus.READY     = rdy_q;
  assign bus.STATE     = state_q;

endmodule
